// File: rtl/timer0_counter_if.sv
// Bus bundle between the CPU/prescaler side and the timer0 count stage.
// The oc0 pin exists only when TIMER0_OC_PIN_EN is defined.
interface timer0_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             tick_in;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] tcnt;
  logic [WIDTH-1:0] ocr;
  logic [3:0]       ctrl;
  logic             ovf_flag;
  logic             cmp_flag;
  logic             irq;
`ifdef TIMER0_OC_PIN_EN
  logic             oc0;
`endif

  modport master (
    output tick_in, wr_en, wr_addr, wr_data,
    input  tcnt, ocr, ctrl, ovf_flag, cmp_flag, irq
`ifdef TIMER0_OC_PIN_EN
    , input oc0
`endif
  );

  modport slave (
    input  tick_in, wr_en, wr_addr, wr_data,
    output tcnt, ocr, ctrl, ovf_flag, cmp_flag, irq
`ifdef TIMER0_OC_PIN_EN
    , output oc0
`endif
  );
endinterface

// File: rtl/timer0_counter.sv
// Timer0 count stage: tick edge detect, 8-bit normal/CTC counter, sticky flags, irq.
// Optional compare output pin oc0 enabled by defining TIMER0_OC_PIN_EN.
module timer0_counter #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  timer0_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             tick_q,   tick_d;
  logic [WIDTH-1:0] tcnt_q,   tcnt_d;
  logic [WIDTH-1:0] ocr_q,    ocr_d;
  logic [3:0]       ctrl_q,   ctrl_d;
  logic             ovf_q,    ovf_d;
  logic             cmp_q,    cmp_d;
  logic             evt;
  logic             match;
  logic             wr_tcnt;
`ifdef TIMER0_OC_PIN_EN
  logic             oc0_q,    oc0_d;
`endif

  always_comb begin
    tick_d  = bus.tick_in;
    tcnt_d  = tcnt_q;
    ocr_d   = ocr_q;
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    cmp_d   = cmp_q;
`ifdef TIMER0_OC_PIN_EN
    oc0_d   = oc0_q;
`endif
    evt     = ctrl_q[0] & bus.tick_in & ~tick_q;
    match   = (tcnt_q == ocr_q);
    wr_tcnt = bus.wr_en && (bus.wr_addr == 2'd0);

    if (bus.wr_en) begin
      case (bus.wr_addr)
        2'd0: tcnt_d = bus.wr_data;
        2'd1: ocr_d  = bus.wr_data;
        2'd2: ctrl_d = bus.wr_data[3:0];
        default: begin
          if (bus.wr_data[0]) ovf_d = 1'b0;
          if (bus.wr_data[1]) cmp_d = 1'b0;
        end
      endcase
    end

    // Event handling follows the write decode so a flag set overrides a same-cycle
    // clear; a TCNT write suppresses the event entirely.
    if (evt && !wr_tcnt) begin
      if (match) begin
        cmp_d = 1'b1;
`ifdef TIMER0_OC_PIN_EN
        oc0_d = ~oc0_q;
`endif
      end
      if (ctrl_q[1] && match) tcnt_d = '0;
      else                    tcnt_d = tcnt_q + WIDTH'(1);
      if (tcnt_q == CNT_MAX)  ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= 1'b1;
      tcnt_q <= '0;
      ocr_q  <= '0;
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
      cmp_q  <= 1'b0;
`ifdef TIMER0_OC_PIN_EN
      oc0_q  <= 1'b0;
`endif
    end else begin
      tick_q <= tick_d;
      tcnt_q <= tcnt_d;
      ocr_q  <= ocr_d;
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      cmp_q  <= cmp_d;
`ifdef TIMER0_OC_PIN_EN
      oc0_q  <= oc0_d;
`endif
    end
  end

  assign bus.tcnt     = tcnt_q;
  assign bus.ocr      = ocr_q;
  assign bus.ctrl     = ctrl_q;
  assign bus.ovf_flag = ovf_q;
  assign bus.cmp_flag = cmp_q;
  assign bus.irq      = (ovf_q & ctrl_q[2]) | (cmp_q & ctrl_q[3]);
`ifdef TIMER0_OC_PIN_EN
  assign bus.oc0      = oc0_q;
`endif

endmodule
